// File: rtl/pixel_col_merger.sv
// Pixel column merger: per-row hit capture, round-robin arbitration and a FWFT column FIFO.
// Optional drop counter (dropCount port) enabled by defining COL_DROP_CNT_EN.
module pixel_col_merger #(
  parameter int NROWS = 16,
  parameter int DATAW = 40,
  parameter int COLW  = 4,
  parameter int DEPTH = 8,
  parameter int CNTW  = 8,
  localparam int ROWW = $clog2(NROWS),
  localparam int OCCW = $clog2(DEPTH) + 1,
  localparam int OUTW = COLW + ROWW + DATAW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLW-1:0]        colID,
  input  logic [NROWS-1:0]       disDataReadout,
  input  logic [NROWS-1:0]       hitValid,
  input  logic [NROWS*DATAW-1:0] hitData,
  output logic [OUTW-1:0]        dnData,
  output logic [OCCW-1:0]        dnHits,
  input  logic                   dnRead
`ifdef COL_DROP_CNT_EN
  , output logic [CNTW-1:0]      dropCount
`endif
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int ENTW = ROWW + DATAW;

  logic [NROWS-1:0] full_q, full_d;
  logic [DATAW-1:0] hold_q [NROWS];
  logic [DATAW-1:0] hold_d [NROWS];
  logic [ROWW-1:0]  last_grant_q, last_grant_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
  logic [OCCW-1:0]  occ_q, occ_d;
  logic [ENTW-1:0]  head_q, head_d;
  logic [ENTW-1:0]  mem_q [DEPTH];
  logic [ENTW-1:0]  wr_entry_s;
  logic [ROWW:0]    cand_s;
  logic [ROWW-1:0]  gnt_row_s;
  logic             gnt_found_s, can_write_s, push_s, pop_s;
  logic [NROWS-1:0] gnt_s, cap_s;

  // Round-robin search for the first full row after the last granted one.
  always_comb begin
    cand_s      = {(ROWW+1){1'b0}};
    gnt_row_s   = last_grant_q;
    gnt_found_s = 1'b0;
    for (int i = 1; i <= NROWS; i++) begin
      cand_s = {1'b0, last_grant_q} + (ROWW+1)'(i);
      cand_s = (cand_s >= (ROWW+1)'(NROWS)) ? cand_s - (ROWW+1)'(NROWS) : cand_s;
      if (!gnt_found_s && full_q[cand_s[ROWW-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_row_s   = cand_s[ROWW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // FIFO push/pop, pointer and occupancy update, and the next registered head word.
  always_comb begin
    can_write_s = (occ_q < OCCW'(DEPTH)) || (dnRead && (occ_q != {OCCW{1'b0}}));
    push_s      = can_write_s && gnt_found_s;
    pop_s       = dnRead && (occ_q != {OCCW{1'b0}});
    wr_entry_s  = {gnt_row_s, hold_q[gnt_row_s]};
    rd_next_s   = rd_ptr_q + PTRW'(1'b1);
    wr_ptr_d    = push_s ? wr_ptr_q + PTRW'(1'b1) : wr_ptr_q;
    rd_ptr_d    = pop_s ? rd_next_s : rd_ptr_q;
    occ_d       = occ_q + OCCW'(push_s) - OCCW'(pop_s);
    // Head is kept as a register so dnData never depends on the memory read path.
    if (occ_d == {OCCW{1'b0}}) begin
      head_d = {ENTW{1'b0}};
    end else if (pop_s) begin
      head_d = (occ_q == OCCW'(1'b1)) ? wr_entry_s : mem_q[rd_next_s];
    end else if (occ_q == {OCCW{1'b0}}) begin
      head_d = wr_entry_s;
    end else begin
      head_d = head_q;
    end
  end

  // Per-row hold registers: capture into an empty or just-granted hold, otherwise drop.
  always_comb begin
    gnt_s        = push_s ? (NROWS'(1'b1) << gnt_row_s) : {NROWS{1'b0}};
    cap_s        = hitValid & ~disDataReadout;
    last_grant_d = push_s ? gnt_row_s : last_grant_q;
    full_d       = full_q;
    for (int r = 0; r < NROWS; r++) begin
      hold_d[r] = hold_q[r];
      if (cap_s[r] && (!full_q[r] || gnt_s[r])) begin
        full_d[r] = 1'b1;
        hold_d[r] = hitData[r*DATAW +: DATAW];
      end else if (gnt_s[r]) begin
        full_d[r] = 1'b0;
      end else begin
        full_d[r] = full_q[r];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= {NROWS{1'b0}};
      last_grant_q <= ROWW'(NROWS - 1);
      wr_ptr_q     <= {PTRW{1'b0}};
      rd_ptr_q     <= {PTRW{1'b0}};
      occ_q        <= {OCCW{1'b0}};
      head_q       <= {ENTW{1'b0}};
      for (int r = 0; r < NROWS; r++) hold_q[r] <= {DATAW{1'b0}};
    end else begin
      full_q       <= full_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      for (int r = 0; r < NROWS; r++) hold_q[r] <= hold_d[r];
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_entry_s;
  end

  assign dnData = {colID, head_q};
  assign dnHits = occ_q;

`ifdef COL_DROP_CNT_EN
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
  logic            drop_any_s;

  // One increment per cycle with any dropped hit, saturating.
  always_comb begin
    drop_any_s = |(cap_s & full_q & ~gnt_s);
    if (drop_any_s && (drop_cnt_q != {CNTW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNTW'(1'b1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= {CNTW{1'b0}};
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign dropCount = drop_cnt_q;
`endif

endmodule
